// File: rtl/quad_pkg.sv
// Shared types and step decoding for the quadrature decoder.
// States are encoded {A,B}; the up sequence runs S00->S10->S11->S01.
package quad_pkg;

    typedef enum logic [1:0] {
        S00 = 2'b00,
        S01 = 2'b01,
        S10 = 2'b10,
        S11 = 2'b11
    } qstate_t;

    typedef struct packed {
        logic valid;
        logic up;
        logic illegal;
    } step_t;

    // Position of a state along the up sequence (Gray to binary).
    function automatic logic [1:0] qpos(qstate_t s);
        logic [1:0] v;
        v = s;
        return {v[0], v[1] ^ v[0]};
    endfunction

    function automatic step_t step_decode(qstate_t old_s, qstate_t new_s);
        logic [1:0] d;
        step_t      r;
        d = qpos(new_s) - qpos(old_s);
        r = '0;
        unique case (d)
            2'd1: begin
                r.valid = 1'b1;
                r.up    = 1'b1;
            end
            2'd3: begin
                r.valid = 1'b1;
                r.up    = 1'b0;
            end
            2'd2: r.illegal = 1'b1;
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/glitch_filter.sv
// One quadrature channel: input synchronizer followed by a
// persistence filter that needs FILT differing cycles to update.
module glitch_filter #(
    parameter int FILT        = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic d,
    output logic sync_out,
    output logic filt
);

    localparam int CW = $clog2(FILT + 1);
    localparam logic [CW-1:0] LAST = CW'(FILT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   filt_q;
    logic                   filt_d;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign filt     = filt_q;

    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (load) begin
            filt_d = sync_out;
        end else if (sync_out != filt_q) begin
            if (cnt_q == LAST) begin
                filt_d = sync_out;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered A/B phases to step strobe, direction,
// sticky illegal-transition flag and a warm-up ready indication.
import quad_pkg::*;

module quad_decoder #(
    parameter int FILT        = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_in,
    input  logic b_in,
    input  logic clear_err,
    output logic en,
    output logic up,
    output logic err,
    output logic ready
);

    logic    sync_a;
    logic    sync_b;
    logic    filt_a;
    logic    filt_b;
    logic    warm;
    qstate_t filt_s;
    qstate_t state_q;
    qstate_t state_d;
    step_t   step;
    logic    en_q, en_d;
    logic    up_q, up_d;
    logic    err_q, err_d;
    logic    ready_q, ready_d;
    logic [2:0] wcnt_q, wcnt_d;

    assign warm = !ready_q;

    glitch_filter #(
        .FILT       (FILT),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_filt_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (warm),
        .d       (a_in),
        .sync_out(sync_a),
        .filt    (filt_a)
    );

    glitch_filter #(
        .FILT       (FILT),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_filt_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (warm),
        .d       (b_in),
        .sync_out(sync_b),
        .filt    (filt_b)
    );

    assign filt_s = qstate_t'({filt_a, filt_b});
    assign step   = step_decode(state_q, filt_s);

    always_comb begin
        state_d = state_q;
        en_d    = 1'b0;
        up_d    = up_q;
        err_d   = err_q;
        ready_d = ready_q;
        wcnt_d  = wcnt_q;
        if (warm) begin
            // Track what the filters load so no step fires at ready.
            wcnt_d  = wcnt_q + 3'd1;
            state_d = qstate_t'({sync_a, sync_b});
            if (wcnt_q == 3'(SYNC_STAGES)) ready_d = 1'b1;
            if (clear_err) err_d = 1'b0;
        end else begin
            state_d = filt_s;
            unique case (1'b1)
                step.valid: begin
                    en_d = 1'b1;
                    up_d = step.up;
                end
                step.illegal: err_d = 1'b1;
                default: ;
            endcase
            if (clear_err && !step.illegal) err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S00;
            en_q    <= 1'b0;
            up_q    <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            up_q    <= up_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign en    = en_q;
    assign up    = up_q;
    assign err   = err_q;
    assign ready = ready_q;

endmodule
